// File: rtl/ctrl_time_pkg.sv
// Shared constants for the time-scheduled value sequencer.
`ifndef EXTENDED_SINGLE
`define EXTENDED_SINGLE 64
`endif

package ctrl_time_pkg;
   localparam int TW_DEF       = 12;               // counter / breakpoint time width
   localparam int DW_DEF       = `EXTENDED_SINGLE; // breakpoint value width
   localparam int INIT_VAL_DEF = 0;                // output before the first fire
   localparam int IDX_W        = 8;                // idx / n_used / address width
endpackage

// File: rtl/ctrl_time_tbl.sv
// Breakpoint table: stores (time, value) per entry and presents the time of
// entry idx+1 (next to fire) and the value of entry idx (last fired).
// Optional feature macro: CTRL_TIME_SEQ_LOAD_EN selects a writable register
// file; otherwise the table is unpacked from flat input buses.
module ctrl_time_tbl
   import ctrl_time_pkg::*;
#(
   parameter int N_PTS = 15,
   parameter int TW    = TW_DEF,
   parameter int DW    = DW_DEF
) (
`ifdef CTRL_TIME_SEQ_LOAD_EN
   input  logic             clk,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_addr,
   input  logic [TW-1:0]    wr_time,
   input  logic [DW-1:0]    wr_value,
`else
   input  logic [N_PTS*TW-1:0] time_flat,
   input  logic [N_PTS*DW-1:0] value_flat,
`endif
   input  logic [IDX_W-1:0] idx,
   output logic [TW-1:0]    nxt_time,
   output logic [DW-1:0]    cur_val
);

   logic [TW-1:0] ent_time [N_PTS];
   logic [DW-1:0] ent_val  [N_PTS];

`ifdef CTRL_TIME_SEQ_LOAD_EN
   logic [TW-1:0] time_q [N_PTS];
   logic [TW-1:0] time_d [N_PTS];
   logic [DW-1:0] value_q [N_PTS];
   logic [DW-1:0] value_d [N_PTS];

   // Write decode: addresses 1..N_PTS map to slots 0..N_PTS-1, others ignored.
   always_comb begin
      time_d  = time_q;
      value_d = value_q;
      for (int k = 0; k < N_PTS; k++) begin
         if (wr_en && (wr_addr == IDX_W'(k + 1))) begin
            time_d[k]  = wr_time;
            value_d[k] = wr_value;
         end
      end
   end

   // Table storage; intentionally not reset so contents survive sta.
   always_ff @(posedge clk) begin
      time_q  <= time_d;
      value_q <= value_d;
   end

   // Expose stored entries to the read mux.
   always_comb begin
      for (int k = 0; k < N_PTS; k++) begin
         ent_time[k] = time_q[k];
         ent_val[k]  = value_q[k];
      end
   end
`else
   // Unpack flat buses: entry k lives in slice k-1.
   always_comb begin
      for (int k = 0; k < N_PTS; k++) begin
         ent_time[k] = time_flat[k*TW +: TW];
         ent_val[k]  = value_flat[k*DW +: DW];
      end
   end
`endif

   // Read mux: time of entry idx+1 and value of entry idx (zero when out of range).
   always_comb begin
      nxt_time = '0;
      cur_val  = '0;
      for (int k = 0; k < N_PTS; k++) begin
         if (idx == IDX_W'(k))     nxt_time = ent_time[k];
         if (idx == IDX_W'(k + 1)) cur_val  = ent_val[k];
      end
   end

endmodule

// File: rtl/ctrl_time_seq.sv
// Time-scheduled value sequencer: steps through time-ordered breakpoints,
// one per match of the free-running counter, and registers the value of the
// last fired breakpoint onto y.
// Optional feature macro: CTRL_TIME_SEQ_LOAD_EN (write port instead of flat buses).
module ctrl_time_seq
   import ctrl_time_pkg::*;
#(
   parameter int            N_PTS    = 15,
   parameter int            TW       = TW_DEF,
   parameter int            DW       = DW_DEF,
   parameter logic [DW-1:0] INIT_VAL = DW'(INIT_VAL_DEF)
) (
   input  logic             clk,
   input  logic             sta,
   input  logic [TW-1:0]    counter,
   input  logic [IDX_W-1:0] n_used,
   input  logic             rearm,
`ifdef CTRL_TIME_SEQ_LOAD_EN
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_addr,
   input  logic [TW-1:0]    wr_time,
   input  logic [DW-1:0]    wr_value,
`else
   input  logic [N_PTS*TW-1:0] time_flat,
   input  logic [N_PTS*DW-1:0] value_flat,
`endif
   output logic [DW-1:0]    y,
   output logic [IDX_W-1:0] idx,
   output logic             done
);

   logic [IDX_W-1:0] idx_q, idx_d;
   logic [DW-1:0]    y_q, y_d;
   logic [IDX_W-1:0] n_eff;
   logic [TW-1:0]    nxt_time, match_time;
   logic [DW-1:0]    cur_val;
   logic             fire;

   ctrl_time_tbl #(.N_PTS(N_PTS), .TW(TW), .DW(DW)) u_tbl (
`ifdef CTRL_TIME_SEQ_LOAD_EN
      .clk      (clk),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_time  (wr_time),
      .wr_value (wr_value),
`else
      .time_flat  (time_flat),
      .value_flat (value_flat),
`endif
      .idx      (idx_q),
      .nxt_time (nxt_time),
      .cur_val  (cur_val)
   );

   // Next-state: one fire per clock at counter == time-1 (mod 2^TW); rearm wins.
   always_comb begin
      n_eff = n_used;
      if (n_used > IDX_W'(N_PTS)) n_eff = IDX_W'(N_PTS);
      match_time = nxt_time - TW'(1);
      fire       = (idx_q < n_eff) && (counter == match_time);
      idx_d      = idx_q;
      if (rearm)     idx_d = '0;
      else if (fire) idx_d = idx_q + IDX_W'(1);
      // y follows idx one edge later, so it is built from the current idx.
      y_d = (idx_q == '0) ? INIT_VAL : cur_val;
   end

   // State registers; sta clears them immediately.
   always_ff @(posedge clk or posedge sta) begin
      if (sta) begin
         idx_q <= '0;
         y_q   <= INIT_VAL;
      end else begin
         idx_q <= idx_d;
         y_q   <= y_d;
      end
   end

   assign y    = y_q;
   assign idx  = idx_q;
   // Covers completion, n_used = 0, and n_used lowered below idx.
   assign done = (idx_q >= n_eff);

endmodule

// File: tb/tb_ctrl_time_seq.sv
// Self-checking bench for ctrl_time_seq: directed schedules with literal
// expectations plus randomized runs against a behavioural schedule model.
module tb_ctrl_time_seq;
   localparam int N  = 15;
   localparam int TW = 12;
   localparam int DW = 64;
   localparam logic [63:0] INIT = 64'hC0DE_0000_5EED_0001;

   logic clk = 1'b0;
   logic sta, rearm;
   logic [TW-1:0] counter;
   logic [7:0] n_used;
   logic [DW-1:0] y;
   logic [7:0] idx;
   logic done;
`ifdef CTRL_TIME_SEQ_LOAD_EN
   logic wr_en;
   logic [7:0] wr_addr;
   logic [TW-1:0] wr_time;
   logic [DW-1:0] wr_value;
`else
   logic [N*TW-1:0] time_flat;
   logic [N*DW-1:0] value_flat;
`endif

   ctrl_time_seq #(.N_PTS(N), .TW(TW), .DW(DW), .INIT_VAL(INIT)) dut (
      .clk(clk), .sta(sta), .counter(counter), .n_used(n_used), .rearm(rearm),
`ifdef CTRL_TIME_SEQ_LOAD_EN
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_time(wr_time), .wr_value(wr_value),
`else
      .time_flat(time_flat), .value_flat(value_flat),
`endif
      .y(y), .idx(idx), .done(done));

   always #5 clk = ~clk;

   // Schedule table as the bench sees it (1-based).
   int          tm [1:N];
   logic [63:0] vl [1:N];
   // Model state: breakpoints fired so far, and the output one edge behind.
   int          m_idx;
   logic [63:0] m_y;
   int          n_tests = 0;
   int          n_fail  = 0;
   bit          chk_en  = 0;
   int          cnt;

   function automatic int n_eff();
      return (n_used > N) ? N : int'(n_used);
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
      n_tests++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
      end
   endtask

   // Behavioural schedule: y shows the value of whatever idx was before the edge.
   always @(posedge clk or posedge sta) begin
      if (sta) begin
         m_idx = 0;
         m_y   = INIT;
      end else begin
         logic [63:0] ny;
         ny = (m_idx == 0) ? INIT : vl[m_idx];
         if (rearm) m_idx = 0;
         else if (m_idx < n_eff() && int'(counter) == ((tm[m_idx+1] - 1) & 4095)) m_idx++;
         m_y = ny;
      end
   end

   // Every-cycle comparison against the model, sampled mid-cycle.
   always @(posedge clk) begin
      if (chk_en) begin
         #4;
         chk("y", y, m_y);
         chk("idx", {56'd0, idx}, 64'(m_idx));
         chk("done", {63'd0, done}, 64'(m_idx >= n_eff()));
      end
   end

   task automatic tick(input int c, input bit rr);
      @(negedge clk);
      counter = c[TW-1:0];
      rearm   = rr;
      @(posedge clk);
      #4;
   endtask

   // Hold reset while the table is (re)loaded, then release.
   task automatic apply_table(input int nu);
      @(negedge clk);
      sta = 1'b1; rearm = 1'b0; n_used = nu[7:0];
`ifdef CTRL_TIME_SEQ_LOAD_EN
      for (int k = 1; k <= N; k++) begin
         @(negedge clk);
         wr_en = 1'b1; wr_addr = k[7:0]; wr_time = tm[k][TW-1:0]; wr_value = vl[k];
      end
      @(negedge clk);
      wr_en = 1'b0;
`else
      for (int k = 1; k <= N; k++) begin
         time_flat[(k-1)*TW +: TW]  = tm[k][TW-1:0];
         value_flat[(k-1)*DW +: DW] = vl[k];
      end
`endif
      @(negedge clk);
      sta = 1'b0;
   endtask

   task automatic base_table();
      for (int k = 1; k <= N; k++) begin
         tm[k] = 100 * k;
         vl[k] = 64'h1111_0000_0000_0000 * k + 64'(k);
      end
   endtask

   initial begin
      sta = 1'b1; rearm = 1'b0; n_used = 8'd3; counter = '0;
`ifdef CTRL_TIME_SEQ_LOAD_EN
      wr_en = 1'b0; wr_addr = '0; wr_time = '0; wr_value = '0;
`else
      time_flat = '0; value_flat = '0;
`endif
      #2;
      chk("rst_idx", {56'd0, idx}, 64'd0);
      chk("rst_y", y, INIT);
      chk("rst_done_n3", {63'd0, done}, 64'd0);
      n_used = 8'd0; #1;
      chk("rst_done_n0", {63'd0, done}, 64'd1);
      chk_en = 1;

      // Basic schedule 5/9/20.
      base_table();
      tm[1] = 5; tm[2] = 9; tm[3] = 20;
      vl[1] = 64'hAAAA; vl[2] = 64'hBBBB; vl[3] = 64'hCCCC;
      apply_table(3);
      for (int c = 0; c <= 30; c++) begin
         tick(c, 1'b0);
         if (c == 3)  begin chk("s1_idx3", {56'd0, idx}, 64'd0); chk("s1_y3", y, INIT); end
         if (c == 4)  begin chk("s1_idx4", {56'd0, idx}, 64'd1); chk("s1_y4", y, INIT); end
         if (c == 5)  chk("s1_y5", y, 64'hAAAA);
         if (c == 9)  begin chk("s1_y9", y, 64'hBBBB); chk("s1_idx9", {56'd0, idx}, 64'd2); end
         if (c == 19) begin chk("s1_idx19", {56'd0, idx}, 64'd3); chk("s1_done19", {63'd0, done}, 64'd1); end
         if (c == 20) chk("s1_y20", y, 64'hCCCC);
         if (c == 18) chk("s1_done18", {63'd0, done}, 64'd0);
      end

      // Rearm collides with the second breakpoint's match.
      apply_table(3);
      for (int c = 0; c <= 7; c++) tick(c, 1'b0);
      tick(8, 1'b1);
      chk("s2_idx", {56'd0, idx}, 64'd0);
      chk("s2_done", {63'd0, done}, 64'd0);
      chk("s2_y_hold", y, 64'hAAAA);
      tick(9, 1'b0);
      chk("s2_y_init", y, INIT);
      for (int c = 10; c <= 25; c++) tick(c, 1'b0);

`ifdef CTRL_TIME_SEQ_LOAD_EN
      // Rewrite entry 2 mid-run; out-of-range addresses are ignored.
      apply_table(3);
      for (int c = 0; c <= 4; c++) tick(c, 1'b0);
      @(negedge clk);
      counter = 12'd5; wr_en = 1'b1; wr_addr = 8'd2; wr_time = 12'd50; wr_value = vl[2];
      @(posedge clk); #4; tm[2] = 50;
      @(negedge clk);
      counter = 12'd6; wr_addr = 8'd0; wr_time = 12'd8;
      @(posedge clk); #4;
      @(negedge clk);
      counter = 12'd7; wr_addr = 8'd16; wr_time = 12'd8;
      @(posedge clk); #4;
      @(negedge clk); wr_en = 1'b0;
      for (int c = 8; c <= 60; c++) begin
         tick(c, 1'b0);
         if (c == 8)  chk("ld_idx8", {56'd0, idx}, 64'd1);
         if (c == 49) chk("ld_idx49", {56'd0, idx}, 64'd2);
      end
`endif

      // Async reset between edges at idx=4; table survives.
      tm[4] = 30; tm[5] = 40; vl[4] = 64'hDDDD; vl[5] = 64'hEEEE;
      apply_table(5);
      for (int c = 0; c <= 29; c++) tick(c, 1'b0);
      chk("s3_idx_pre", {56'd0, idx}, 64'd4);
      #2; sta = 1'b1; #1;
      chk("s3_async_idx", {56'd0, idx}, 64'd0);
      chk("s3_async_y", y, INIT);
      @(negedge clk); sta = 1'b0;
      for (int c = 0; c <= 45; c++) begin
         tick(c, 1'b0);
         if (c == 29) chk("s3_idx29", {56'd0, idx}, 64'd4);
         if (c == 40) begin chk("s3_y40", y, 64'hEEEE); chk("s3_done40", {63'd0, done}, 64'd1); end
      end

      // Duplicate times 7/7: second fire waits a full counter period.
      base_table();
      tm[1] = 7; tm[2] = 7;
      apply_table(2);
      for (int i = 0; i <= 4096 + 10; i++) begin
         tick(i % 4096, 1'b0);
         if (i == 6)        chk("s4_idx_first", {56'd0, idx}, 64'd1);
         if (i == 4095)     chk("s4_idx_wait", {56'd0, idx}, 64'd1);
         if (i == 4096 + 6) chk("s4_idx_second", {56'd0, idx}, 64'd2);
      end

      // Saturation with time 0 (fires at 4095) and a counter wrap after completion.
      base_table();
      tm[1] = 0;
      for (int k = 2; k <= N; k++) tm[k] = 10 * k;
      apply_table(15);
      for (int i = 0; i <= 4302; i++) begin
         tick((4090 + i) % 4096, 1'b0);
         if (i == 4)    chk("s5_idx_pre0", {56'd0, idx}, 64'd0);
         if (i == 5)    chk("s5_idx_t0", {56'd0, idx}, 64'd1);
         if (i == 156)  begin chk("s5_y_last", y, vl[15]); chk("s5_done", {63'd0, done}, 64'd1); end
         if (i == 4302) begin chk("s5_idx_end", {56'd0, idx}, 64'd15); chk("s5_y_end", y, vl[15]); end
      end

      // Randomized schedules, rearms, counter jumps, n_used changes.
      for (int r = 0; r < 4; r++) begin
         int t, nu;
         nu = (r == 0) ? 0 : (r == 3) ? 20 : int'($urandom_range(1, 15));
         t = (r == 2) ? 0 : int'($urandom_range(0, 40));
         for (int k = 1; k <= N; k++) begin
            tm[k] = t;
            vl[k] = {$urandom, $urandom};
            t += ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 60));
         end
         apply_table(nu);
         cnt = $urandom_range(0, 4095);
         for (int i = 0; i < 1500; i++) begin
            bit rr;
            rr = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 49) == 0) cnt = $urandom_range(0, 4095);
            if (r == 1 && i == 700) n_used = (m_idx > 0) ? 8'(m_idx - 1) : 8'd0;
            tick(cnt, rr);
            cnt = (cnt + 1) % 4096;
         end
         if (r == 0) begin
            chk("r0_done", {63'd0, done}, 64'd1);
            chk("r0_idx", {56'd0, idx}, 64'd0);
            chk("r0_y", y, INIT);
         end
      end

      chk_en = 0;
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
